// File: rtl/dma_chan_ctrl.sv
// dma_chan_ctrl: single-channel DMA sequencer, CPU-programmed, acquires the bus via hrq/hlda.
// Latency: 5 cycles per byte after hlda (S1,S2,WAIT,S3,S4) when the source is already ready.
// Backpressure: io_ready/mem_ready stretch the source strobe; WAIT_MAX low cycles abort with err.
module dma_chan_ctrl #(
    parameter int ADDR_W   = 16,
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic              wr,
    input  logic [2:0]        reg_sel,
    input  logic [7:0]        cpu_din,
    input  logic              dreq,
    input  logic              hlda,
    input  logic              io_ready,
    input  logic              mem_ready,
    output logic              hrq,
    output logic              dack0,
    output logic [1:0]        aen,
    output logic              ior,
    output logic              iow,
    output logic              memr,
    output logic              memw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [CNT_W-1:0]  cur_count,
    output logic              busy,
    output logic              tc,
    output logic              err
);

    typedef enum logic [2:0] {IDLE, REQ, S1, S2, WAIT, S3, S4} state_t;

    localparam int WC_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(WAIT_MAX - 1);

    state_t            state;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  base_cnt;
    logic [3:0]        mode;
    logic [WC_W-1:0]   wait_cnt;
    logic              hlda_lost;

    logic       reg_wr;
    logic       en_clr;
    logic       dir;
    logic       src_rdy;
    logic [1:0] aen_own;

    assign reg_wr  = cs & wr;
    // Only the enable bit may be touched while a transfer is in flight.
    assign en_clr  = reg_wr && (reg_sel == 3'd4) && !cpu_din[2];
    assign dir     = mode[0];
    assign src_rdy = dir ? mem_ready : io_ready;
    assign aen_own = dir ? 2'b01 : 2'b11;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            base_addr <= '0;
            base_cnt  <= '0;
            mem_addr  <= '0;
            cur_count <= '0;
            mode      <= '0;
            wait_cnt  <= '0;
            hlda_lost <= 1'b0;
            hrq       <= 1'b0;
            dack0     <= 1'b0;
            aen       <= 2'b00;
            ior       <= 1'b0;
            iow       <= 1'b0;
            memr      <= 1'b0;
            memw      <= 1'b0;
            busy      <= 1'b0;
            tc        <= 1'b0;
            err       <= 1'b0;
        end else begin
            tc <= 1'b0;

            if (reg_wr && !busy) begin
                case (reg_sel)
                    3'd0: begin base_addr[7:0]  <= cpu_din; mem_addr[7:0]   <= cpu_din; end
                    3'd1: begin base_addr[15:8] <= cpu_din; mem_addr[15:8]  <= cpu_din; end
                    3'd2: begin base_cnt[7:0]   <= cpu_din; cur_count[7:0]  <= cpu_din; end
                    3'd3: begin base_cnt[15:8]  <= cpu_din; cur_count[15:8] <= cpu_din; end
                    3'd4: begin mode <= cpu_din[3:0]; err <= 1'b0; end
                    default: ;
                endcase
            end else if (en_clr) begin
                mode[2] <= 1'b0;
            end

            if (!hlda && (state == S1 || state == S2 || state == WAIT || state == S3))
                hlda_lost <= 1'b1;

            case (state)
                IDLE: begin
                    if (mode[2] && dreq) begin
                        state <= REQ;
                        hrq   <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                REQ: begin
                    if (!mode[2]) begin
                        state <= IDLE;
                        hrq   <= 1'b0;
                        busy  <= 1'b0;
                    end else if (hlda) begin
                        state     <= S1;
                        dack0     <= 1'b1;
                        aen       <= aen_own;
                        hlda_lost <= 1'b0;
                    end
                end
                S1: begin
                    state <= S2;
                    ior   <= !dir;
                    memr  <= dir;
                end
                S2: begin
                    state    <= WAIT;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (src_rdy) begin
                        state <= S3;
                        ior   <= 1'b0;
                        memr  <= 1'b0;
                        iow   <= dir;
                        memw  <= !dir;
                    end else if (wait_cnt == WC_LAST) begin
                        // Timeout: give the bus back without touching address/count.
                        state <= IDLE;
                        err   <= 1'b1;
                        ior   <= 1'b0;
                        memr  <= 1'b0;
                        hrq   <= 1'b0;
                        dack0 <= 1'b0;
                        aen   <= 2'b00;
                        busy  <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                    end
                end
                S3: begin
                    state <= S4;
                    iow   <= 1'b0;
                    memw  <= 1'b0;
                end
                S4: begin
                    mem_addr  <= mem_addr + ADDR_W'(1);
                    cur_count <= cur_count - CNT_W'(1);
                    if (!hlda_lost && hlda && cur_count == '0) begin
                        tc <= 1'b1;
                        if (mode[1]) begin
                            mem_addr  <= base_addr;
                            cur_count <= base_cnt;
                        end else begin
                            mode[2] <= 1'b0;
                        end
                    end
                    // Keep the bus only for a further byte that is still wanted.
                    if (!hlda_lost && hlda && mode[2] && !en_clr && cur_count != '0 &&
                        (mode[3] || dreq)) begin
                        state <= S1;
                    end else begin
                        state <= IDLE;
                        hrq   <= 1'b0;
                        dack0 <= 1'b0;
                        aen   <= 2'b00;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_chan_ctrl.sv
// Directed plus randomized bench for dma_chan_ctrl; expectations come from a transfer-level model.
module tb_dma_chan_ctrl;

    localparam int WAIT_MAX = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b0;
    logic        wr = 1'b0;
    logic [2:0]  reg_sel = 3'd0;
    logic [7:0]  cpu_din = 8'd0;
    logic        dreq = 1'b0;
    logic        hlda = 1'b0;
    logic        io_ready = 1'b1;
    logic        mem_ready = 1'b1;
    logic        hrq, dack0, ior, iow, memr, memw, busy, tc, err;
    logic [1:0]  aen;
    logic [15:0] mem_addr, cur_count;

    int n_cmp = 0;
    int n_bad = 0;
    int n_ior, n_iow, n_memr, n_memw, n_tc, n_hrq, n_dack, dst_w;
    logic p_ior = 0, p_iow = 0, p_memr = 0, p_memw = 0, p_tc = 0, p_hrq = 0;
    logic [15:0] dq[$];
    int hlda_delay = 0;
    int hlda_wait = 0;
    int ready_mode = 1;

    dma_chan_ctrl #(.ADDR_W(16), .CNT_W(16), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .wr(wr), .reg_sel(reg_sel), .cpu_din(cpu_din),
        .dreq(dreq), .hlda(hlda), .io_ready(io_ready), .mem_ready(mem_ready),
        .hrq(hrq), .dack0(dack0), .aen(aen), .ior(ior), .iow(iow), .memr(memr), .memw(memw),
        .mem_addr(mem_addr), .cur_count(cur_count), .busy(busy), .tc(tc), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_stats();
        n_ior = 0; n_iow = 0; n_memr = 0; n_memw = 0;
        n_tc = 0; n_hrq = 0; n_dack = 0; dst_w = 0;
        dq.delete();
    endtask

    // One cycle: observe at negedge, track bus events, then play CPU (hlda) and device (ready).
    task automatic tick();
        int ns;
        @(negedge clk);
        if (ior && !p_ior) n_ior++;
        if (iow && !p_iow) n_iow++;
        if (memr && !p_memr) n_memr++;
        if (memw && !p_memw) n_memw++;
        if ((memw && !p_memw) || (iow && !p_iow)) dq.push_back(mem_addr);
        if (memw || iow) dst_w++;
        else if (p_memw || p_iow) begin
            chk("dst_strobe_width", 32'(dst_w), 1);
            dst_w = 0;
        end
        if (tc) begin
            n_tc++;
            chk("tc_single_cycle", 32'(p_tc), 0);
        end
        if (hrq && !p_hrq) n_hrq++;
        if (dack0) n_dack++;
        ns = int'(ior) + int'(iow) + int'(memr) + int'(memw);
        chk("strobe_exclusive", 32'(ns > 1), 0);
        chk("aen_needs_dack", 32'(aen != 2'b00 && !dack0), 0);
        p_ior = ior; p_iow = iow; p_memr = memr; p_memw = memw; p_tc = tc; p_hrq = hrq;
        if (!hrq) begin
            hlda = 1'b0;
            hlda_wait = 0;
        end else if (!hlda) begin
            if (hlda_wait >= hlda_delay) hlda = 1'b1;
            else hlda_wait++;
        end
        case (ready_mode)
            0: begin io_ready = 1'b0; mem_ready = 1'b0; end
            1: begin io_ready = 1'b1; mem_ready = 1'b1; end
            default: begin
                io_ready  = ($urandom_range(0, 3) != 0);
                mem_ready = ($urandom_range(0, 3) != 0);
            end
        endcase
    endtask

    task automatic wr_reg(input logic [2:0] sel, input logic [7:0] d);
        cs = 1'b1; wr = 1'b1; reg_sel = sel; cpu_din = d;
        tick();
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic program_chan(input logic [15:0] a, input logic [15:0] c, input logic [7:0] m);
        wr_reg(3'd0, a[7:0]);
        wr_reg(3'd1, a[15:8]);
        wr_reg(3'd2, c[7:0]);
        wr_reg(3'd3, c[15:8]);
        wr_reg(3'd4, m);
    endtask

    initial begin
        logic [15:0] base;
        int          cnt;
        int          ior_cyc;
        logic        dirb;

        // Reset values
        clr_stats();
        tick();
        tick();
        chk("rst_hrq", 32'(hrq), 0);
        chk("rst_dack0", 32'(dack0), 0);
        chk("rst_aen", 32'(aen), 0);
        chk("rst_strobes", 32'({ior, iow, memr, memw}), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_count", 32'(cur_count), 0);
        chk("rst_flags", 32'({busy, tc, err}), 0);
        rst_n = 1'b1;
        tick();

        // Block IO->mem, 4 bytes from 0x0100
        program_chan(16'h0100, 16'd3, 8'b1100);
        clr_stats();
        hlda_delay = 2;
        dreq = 1'b1;
        for (int i = 0; i < 200 && n_tc == 0; i++) tick();
        chk("blk_tc", 32'(n_tc), 1);
        chk("blk_memw", 32'(n_memw), 4);
        chk("blk_ior", 32'(n_ior), 4);
        chk("blk_wrong_dir", 32'(n_iow + n_memr), 0);
        for (int i = 0; i < 4; i++)
            if (dq.size() > i) chk("blk_addr_seq", 32'(dq[i]), 32'(16'h0100 + i));
        chk("blk_end_addr", 32'(mem_addr), 32'h0104);
        chk("blk_dack_cycles", 32'(n_dack), 20);
        for (int i = 0; i < 10; i++) tick();
        chk("blk_no_rerequest", 32'(n_hrq), 1);
        chk("blk_hrq_low", 32'(hrq), 0);
        dreq = 1'b0;

        // Single-byte mem->IO across the address wrap
        program_chan(16'hFFFF, 16'd1, 8'b0101);
        clr_stats();
        hlda_delay = 1;
        dreq = 1'b1;
        for (int i = 0; i < 50 && !dack0; i++) tick();
        chk("sgl_first_grant", 32'(dack0), 1);
        dreq = 1'b0;
        for (int i = 0; i < 50 && busy; i++) tick();
        tick();
        chk("sgl_first_addr", 32'(mem_addr), 32'h0000);
        chk("sgl_first_iow", 32'(n_iow), 1);
        chk("sgl_first_no_tc", 32'(n_tc), 0);
        chk("sgl_bus_released", 32'(hrq), 0);
        dreq = 1'b1;
        for (int i = 0; i < 50 && !dack0; i++) tick();
        dreq = 1'b0;
        for (int i = 0; i < 50 && n_tc == 0; i++) tick();
        chk("sgl_tc", 32'(n_tc), 1);
        chk("sgl_end_addr", 32'(mem_addr), 32'h0001);
        chk("sgl_iow", 32'(n_iow), 2);
        chk("sgl_memr", 32'(n_memr), 2);
        chk("sgl_hrq_cycles", 32'(n_hrq), 2);
        if (dq.size() > 1) chk("sgl_wrap_addr", 32'(dq[1]), 32'h0000);

        // Autoinit, one byte per block at 0x0020
        program_chan(16'h0020, 16'd0, 8'b0110);
        clr_stats();
        dreq = 1'b1;
        for (int i = 0; i < 50 && !dack0; i++) tick();
        dreq = 1'b0;
        for (int i = 0; i < 50 && n_tc == 0; i++) tick();
        tick();
        chk("ai_tc", 32'(n_tc), 1);
        chk("ai_reload_count", 32'(cur_count), 0);
        chk("ai_reload_addr", 32'(mem_addr), 32'h0020);
        chk("ai_idle", 32'(busy), 0);
        dreq = 1'b1;
        for (int i = 0; i < 50 && !dack0; i++) tick();
        chk("ai_restart", 32'(dack0), 1);
        dreq = 1'b0;
        for (int i = 0; i < 50 && n_tc < 2; i++) tick();
        chk("ai_second_tc", 32'(n_tc), 2);
        chk("ai_addr_again", 32'(mem_addr), 32'h0020);
        chk("ai_memw", 32'(n_memw), 2);
        wr_reg(3'd4, 8'h00);

        // Writes while busy are dropped; clearing enable stops after the current byte
        program_chan(16'h0200, 16'd2, 8'b1100);
        clr_stats();
        dreq = 1'b1;
        for (int i = 0; i < 50 && !dack0; i++) tick();
        wr_reg(3'd0, 8'h55);
        wr_reg(3'd2, 8'h77);
        wr_reg(3'd4, 8'b1000);
        for (int i = 0; i < 50 && busy; i++) tick();
        for (int i = 0; i < 20; i++) tick();
        chk("bw_one_byte", 32'(n_memw), 1);
        chk("bw_addr", 32'(mem_addr), 32'h0201);
        chk("bw_count", 32'(cur_count), 1);
        chk("bw_no_tc", 32'(n_tc), 0);
        chk("bw_no_rerequest", 32'(n_hrq), 1);
        dreq = 1'b0;

        // Source never ready: timeout
        program_chan(16'h0040, 16'd5, 8'b0100);
        clr_stats();
        ready_mode = 0;
        dreq = 1'b1;
        for (int i = 0; i < 50 && !ior; i++) tick();
        dreq = 1'b0;
        ior_cyc = ior ? 1 : 0;
        for (int i = 0; i < 40 && !err; i++) begin
            tick();
            if (ior) ior_cyc++;
        end
        chk("to_err", 32'(err), 1);
        chk("to_ior_dropped", 32'(ior), 0);
        chk("to_ior_window", 32'(ior_cyc >= WAIT_MAX && ior_cyc <= WAIT_MAX + 2), 1);
        chk("to_addr_kept", 32'(mem_addr), 32'h0040);
        chk("to_count_kept", 32'(cur_count), 5);
        chk("to_no_memw", 32'(n_memw), 0);
        tick();
        chk("to_bus_released", 32'({hrq, dack0, aen}), 0);
        wr_reg(3'd4, 8'h00);
        chk("to_err_cleared", 32'(err), 0);

        // Asynchronous reset in the middle of WAIT
        wr_reg(3'd4, 8'b0100);
        dreq = 1'b1;
        for (int i = 0; i < 50 && !ior; i++) tick();
        tick();
        tick();
        chk("ar_in_wait", 32'({ior, dack0, hrq}), 32'b111);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_strobes", 32'({ior, iow, memr, memw}), 0);
        chk("ar_bus", 32'({hrq, dack0, aen}), 0);
        chk("ar_busy_addr", 32'({busy, mem_addr}), 0);
        #1 rst_n = 1'b1;
        dreq = 1'b0;
        ready_mode = 1;
        tick();

        // Randomized block transfers against the transfer-level model
        for (int it = 0; it < 6; it++) begin
            base = 16'($urandom);
            cnt = $urandom_range(0, 5);
            dirb = 1'($urandom_range(0, 1));
            hlda_delay = $urandom_range(0, 4);
            ready_mode = 2;
            program_chan(base, 16'(cnt), {7'b0000110, dirb});
            clr_stats();
            dreq = 1'b1;
            for (int i = 0; i < 600 && n_tc == 0; i++) tick();
            dreq = 1'b0;
            tick();
            chk("rnd_tc", 32'(n_tc), 1);
            chk("rnd_dst_pulses", 32'(dirb ? n_iow : n_memw), 32'(cnt + 1));
            chk("rnd_src_pulses", 32'(dirb ? n_memr : n_ior), 32'(cnt + 1));
            chk("rnd_wrong_dir", 32'(dirb ? (n_memw + n_ior) : (n_iow + n_memr)), 0);
            for (int i = 0; i <= cnt; i++)
                if (dq.size() > i) chk("rnd_addr_seq", 32'(dq[i]), 32'(16'(base + 16'(i))));
            chk("rnd_end_addr", 32'(mem_addr), 32'(16'(base + 16'(cnt + 1))));
            chk("rnd_end_count", 32'(cur_count), 32'hFFFF);
            chk("rnd_idle", 32'({busy, hrq}), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
